// File: rtl/reset_sequencer_if.sv
// Reset sequencer request/ack bundle: reset requests and per-domain ready in,
// per-domain resets and status out. The sequencer uses the slave side.
interface reset_sequencer_if #(
  parameter int STAGES = 4
);
  logic              i_rst_n_glitch;
  logic              i_soft_rst;
  logic [STAGES-1:0] iv_stage_ready;
  logic [STAGES-1:0] ov_rst_n_stage;
  logic              o_seq_done;
  logic              o_timeout_err;
  logic [2:0]        ov_fail_stage;

  modport master (
    output i_rst_n_glitch, i_soft_rst, iv_stage_ready,
    input  ov_rst_n_stage, o_seq_done, o_timeout_err, ov_fail_stage
  );

  modport slave (
    input  i_rst_n_glitch, i_soft_rst, iv_stage_ready,
    output ov_rst_n_stage, o_seq_done, o_timeout_err, ov_fail_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases up to STAGES reset domains in fixed order, waiting for each domain's
// ready acknowledge (with timeout) before releasing the next one.
module reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int HOLD_CYC    = 16,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_GAP,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       K_LAST    = 3'(STAGES - 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [2:0]        r_k, w_k_next;
  logic [STAGES-1:0] r_rst_n, w_rst_n_next;
  logic              r_err, w_err_next;
  logic [2:0]        r_fail, w_fail_next;
  logic              w_req;
  logic              w_ready_k;
  logic [STAGES-1:0] w_stage_sel;

  // One-hot decode of the stage currently being released / waited on.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_sel
      assign w_stage_sel[gi] = (r_k == 3'(gi));
    end
  endgenerate

  assign w_ready_k = |(bus.iv_stage_ready & w_stage_sel);
  assign w_req     = ~bus.i_rst_n_glitch | bus.i_soft_rst;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_k_next     = r_k;
    w_rst_n_next = r_rst_n;
    w_err_next   = r_err;
    w_fail_next  = r_fail;

    // Only a software reset clears the sticky error; filtered resets keep it.
    if (bus.i_soft_rst) begin
      w_err_next  = 1'b0;
      w_fail_next = 3'd0;
    end

    if (w_req) begin
      w_state_next = ST_ASSERT;
      w_cnt_next   = '0;
      w_k_next     = 3'd0;
      w_rst_n_next = '0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_rst_n_next = '0;
          if (r_cnt == HOLD_LAST) begin
            w_state_next = ST_RELEASE;
            w_cnt_next   = '0;
            w_k_next     = 3'd0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          w_rst_n_next = r_rst_n | w_stage_sel;
          w_cnt_next   = '0;
          w_state_next = ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_next = ST_WAIT;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_ready_k) begin
            w_cnt_next = '0;
            if (r_k == K_LAST) begin
              w_state_next = ST_DONE;
            end else begin
              w_k_next     = r_k + 3'd1;
              w_state_next = ST_RELEASE;
            end
          end else if (r_cnt == TO_LAST) begin
            w_state_next = ST_ERROR;
            w_cnt_next   = '0;
            w_err_next   = 1'b1;
            w_fail_next  = r_k;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_DONE, ST_ERROR: begin
          w_state_next = r_state;
        end
        default: begin
          w_state_next = ST_ASSERT;
          w_cnt_next   = '0;
          w_k_next     = 3'd0;
          w_rst_n_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_k     <= 3'd0;
      r_rst_n <= '0;
      r_err   <= 1'b0;
      r_fail  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_k     <= w_k_next;
      r_rst_n <= w_rst_n_next;
      r_err   <= w_err_next;
      r_fail  <= w_fail_next;
    end
  end

  assign bus.ov_rst_n_stage = r_rst_n;
  assign bus.o_seq_done     = (r_state == ST_DONE);
  assign bus.o_timeout_err  = r_err;
  assign bus.ov_fail_stage  = r_fail;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: expected outputs come from an
// event-time model (release, done and error cycles computed arithmetically).
module tb_reset_sequencer;
  localparam int S     = 4;
  localparam int HOLD  = 16;
  localparam int GAP   = 8;
  localparam int TO    = 1024;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reset_sequencer_if #(.STAGES(S)) bus ();

  reset_sequencer #(
    .STAGES(S), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TIMEOUT_CYC(TO), .CNT_W(11)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: cycle at which each event becomes visible on the outputs.
  int rise[S];
  int rdy_at[S];
  int done_at = NEVER;
  int err_at = NEVER;
  int err_stg = 0;
  int stk_err = 0;
  int stk_fail = 0;

  task automatic plan(input int start, input int d[S]);
    int t, smp;
    bit alive;
    t = start + HOLD + 1;
    alive = 1'b1;
    done_at = NEVER;
    err_at = NEVER;
    err_stg = 0;
    for (int i = 0; i < S; i++) begin
      rise[i] = NEVER;
      rdy_at[i] = NEVER;
      if (alive) begin
        rise[i] = t;
        if (d[i] >= TO) begin
          err_at = t + GAP + TO;
          err_stg = i;
          alive = 1'b0;
        end else begin
          rdy_at[i] = t + GAP + d[i];
          smp = t + GAP + ((d[i] > 0) ? d[i] : 0);
          if (i == S - 1) done_at = smp + 1;
          else t = smp + 2;
        end
      end
    end
  endtask

  function automatic logic [S-1:0] exp_rst(input int c);
    logic [S-1:0] v;
    for (int i = 0; i < S; i++) v[i] = (c >= rise[i]);
    return v;
  endfunction

  function automatic logic exp_done(input int c);
    return c >= done_at;
  endfunction

  function automatic logic exp_err(input int c);
    return (c >= err_at) ? 1'b1 : 1'(stk_err);
  endfunction

  function automatic logic [2:0] exp_fail(input int c);
    return (c >= err_at) ? 3'(err_stg) : 3'(stk_fail);
  endfunction

  task automatic drive_ready();
    for (int i = 0; i < S; i++) bus.iv_stage_ready[i] = (cyc >= rdy_at[i]);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.i_soft_rst = 1'b0;
    bus.i_rst_n_glitch = 1'b1;
    drive_ready();
  endtask

  task automatic rand_delays(output int d[S]);
    for (int i = 0; i < S; i++) d[i] = int'($urandom_range(52)) - 12;
  endtask

  task automatic soft_pulse(input int d[S]);
    bus.i_soft_rst = 1'b1;
    stk_err = 0;
    stk_fail = 0;
    plan(cyc + 1, d);
  endtask

  task automatic glitch_low(input int d[S]);
    bus.i_rst_n_glitch = 1'b0;
    stk_err = int'(exp_err(cyc));
    stk_fail = int'(exp_fail(cyc));
    plan(cyc + 1, d);
  endtask

  task automatic test_reset();
    int d[S];
    for (int i = 0; i < S; i++) rdy_at[i] = NEVER;
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      next_cycle();
      bus.i_soft_rst = 1'($urandom_range(1));
      bus.i_rst_n_glitch = 1'($urandom_range(1));
      n_vec++;
      if (bus.ov_rst_n_stage !== 4'h0 || bus.o_seq_done !== 1'b0 ||
          bus.o_timeout_err !== 1'b0 || bus.ov_fail_stage !== 3'd0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d rst_n=%h done=%b err=%b fail=%0d want all zero",
                 cyc, bus.ov_rst_n_stage, bus.o_seq_done, bus.o_timeout_err, bus.ov_fail_stage);
      end
    end
    rst = 1'b0;
    bus.i_soft_rst = 1'b0;
    bus.i_rst_n_glitch = 1'b1;
    for (int i = 0; i < S; i++) d[i] = -1000;
    stk_err = 0;
    stk_fail = 0;
    plan(cyc, d);
    drive_ready();
    $display("reset released at cycle %0d, stage0 expected at %0d", cyc, rise[0]);
  endtask

  task automatic test_normal();
    while (cyc < done_at + 4) begin
      next_cycle();
      n_vec++;
      if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
          bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
        n_bad++;
        $display("FAIL normal cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                 cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                 bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
      end
    end
    // Ready drops after DONE must not disturb anything.
    for (int i = 0; i < S; i++) rdy_at[i] = NEVER;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      n_vec++;
      if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc)) begin
        n_bad++;
        $display("FAIL done_ready_drop cyc=%0d rst_n=%h/%h done=%b/%b",
                 cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc));
      end
    end
    $display("normal sequence through cycle %0d, done expected at %0d", cyc, done_at);
  endtask

  task automatic test_hold_restart();
    int d[S];
    int p, s0;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 10 : int'($urandom_range(HOLD - 1));
      rand_delays(d);
      soft_pulse(d);
      s0 = cyc + 1;
      while (cyc < done_at + 3) begin
        next_cycle();
        n_vec++;
        if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
            bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
          n_bad++;
          $display("FAIL hold_restart cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                   cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                   bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
        end
        if (cyc == s0 + p) glitch_low(d);
      end
      $display("hold restart glitch at rel %0d, stage0 expected rel %0d", p, rise[0] - s0);
    end
  endtask

  task automatic test_late_ready();
    int d[S];
    for (int it = 0; it < 4; it++) begin
      rand_delays(d);
      if (it == 0) d[1] = 50 - GAP;
      soft_pulse(d);
      while (cyc < done_at + 3) begin
        next_cycle();
        n_vec++;
        if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
            bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
          n_bad++;
          $display("FAIL late_ready cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                   cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                   bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
        end
      end
      $display("late ready run %0d: delays %0d %0d %0d %0d done at %0d",
               it, d[0], d[1], d[2], d[3], done_at);
    end
  endtask

  task automatic test_timeout();
    int d[S];
    rand_delays(d);
    d[2] = TO;
    soft_pulse(d);
    while (cyc < err_at + 10) begin
      next_cycle();
      n_vec++;
      if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
          bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
        n_bad++;
        $display("FAIL timeout cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                 cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                 bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
      end
    end
    $display("timeout on stage %0d expected at %0d (stage2 rose %0d)", err_stg, err_at, rise[2]);
  endtask

  task automatic test_error_clear();
    int d[S];
    int len;
    len = int'($urandom_range(3, 1));
    rand_delays(d);
    glitch_low(d);
    for (int l = 1; l < len; l++) begin
      next_cycle();
      glitch_low(d);
    end
    while (cyc < done_at + 3) begin
      next_cycle();
      n_vec++;
      if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
          bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
        n_bad++;
        $display("FAIL err_sticky cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                 cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                 bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
      end
    end
    $display("re-sequence after glitch (%0d cycles low) done at %0d", len, done_at);
    rand_delays(d);
    soft_pulse(d);
    while (cyc < done_at + 3) begin
      next_cycle();
      n_vec++;
      if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
          bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
        n_bad++;
        $display("FAIL err_clear cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                 cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                 bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
      end
    end
    $display("soft reset cleared error, new sequence done at %0d", done_at);
  endtask

  task automatic test_mid_reset();
    int d[S];
    int d2[S];
    int k, trig;
    bit fired;
    for (int it = 0; it < 4; it++) begin
      rand_delays(d);
      k = int'($urandom_range(S - 1));
      d[k] = int'($urandom_range(20));
      soft_pulse(d);
      trig = rdy_at[k];
      fired = 1'b0;
      while (cyc < done_at + 3) begin
        next_cycle();
        n_vec++;
        if (bus.ov_rst_n_stage !== exp_rst(cyc) || bus.o_seq_done !== exp_done(cyc) ||
            bus.o_timeout_err !== exp_err(cyc) || bus.ov_fail_stage !== exp_fail(cyc)) begin
          n_bad++;
          $display("FAIL mid_reset cyc=%0d rst_n=%h/%h done=%b/%b err=%b/%b fail=%0d/%0d",
                   cyc, bus.ov_rst_n_stage, exp_rst(cyc), bus.o_seq_done, exp_done(cyc),
                   bus.o_timeout_err, exp_err(cyc), bus.ov_fail_stage, exp_fail(cyc));
        end
        if (!fired && cyc == trig) begin
          fired = 1'b1;
          rand_delays(d2);
          if (it[0]) glitch_low(d2);
          else soft_pulse(d2);
        end
      end
      $display("reset collides with ready of stage %0d at cycle %0d, restart done at %0d",
               k, trig, done_at);
    end
  endtask

  initial begin
    bus.i_rst_n_glitch = 1'b1;
    bus.i_soft_rst = 1'b0;
    bus.iv_stage_ready = '0;
    for (int i = 0; i < S; i++) begin
      rise[i] = NEVER;
      rdy_at[i] = NEVER;
    end
    test_reset();
    test_normal();
    test_hold_restart();
    test_late_ready();
    test_timeout();
    test_error_clear();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the filtered, stretched active-low reset from the reset glitch filter and releases up to STAGES downstream reset domains one at a time, in a fixed order.
- Domain order is fixed (e.g. PLL/clocking, buffer memories, forwarding pipeline, host interface).
- Before releasing the next domain, each released domain must acknowledge ready (init done/locked) within a timeout.
- A timeout is latched as a sticky error that software can read.

Parameters:
- STAGES, 4: number of sequenced reset domains (1..8).
- HOLD_CYC, 16: consecutive request-free cycles required before stage 0 is released.
- GAP_CYC, 8: cycles after a stage's release before its ready input is sampled.
- TIMEOUT_CYC, 1024: maximum WAIT cycles per stage before error.
- CNT_W, 11: counter width; must hold max(HOLD_CYC, GAP_CYC, TIMEOUT_CYC).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_rst_n_glitch  input  1  filtered active-low reset request from the glitch filter, synchronous to i_clk.
- i_soft_rst  input  1  single-cycle software reset pulse.
- iv_stage_ready  input  STAGES  per-domain ready/ack, level.
- ov_rst_n_stage  output  STAGES  per-domain active-low resets, registered.
- o_seq_done  output  1  all stages released and acknowledged.
- o_timeout_err  output  1  sticky timeout flag.
- ov_fail_stage  output  3  index of the stage that timed out.

Behaviour:
- Request signal: req = ~i_rst_n_glitch | i_soft_rst.
- i_rst (sync) drives the following; all outputs are registered or decoded from registered state:
  - state=ASSERT, counter=0, k=0;
  - ov_rst_n_stage=0;
  - o_seq_done=0, o_timeout_err=0, ov_fail_stage=0.
- States: ASSERT, RELEASE, GAP, WAIT, DONE, ERROR.
- ASSERT:
  - All ov_rst_n_stage=0.
  - Counter increments each cycle req=0; req=1 clears it.
  - When req=0 and counter==HOLD_CYC-1: go to RELEASE with k=0.
- RELEASE (1 cycle): set ov_rst_n_stage[k]=1 (visible next cycle), counter=0, go to GAP. Lower stages stay released.
- GAP: count GAP_CYC cycles, then go to WAIT with counter=0. iv_stage_ready is ignored in GAP.
- WAIT:
  - If iv_stage_ready[k]=1: go to DONE when k==STAGES-1, else k=k+1 and go to RELEASE.
  - Else the counter increments; on the cycle counter==TIMEOUT_CYC-1 with ready still low, go to ERROR.
  - Entering ERROR sets o_timeout_err=1 and ov_fail_stage=k.
- ERROR: stages <=k stay released; stages >k stay in reset. Remains here until req.
- DONE: o_seq_done=1 (Moore decode of state==DONE). Later drops of iv_stage_ready are ignored.
- req=1 in any state:
  - Next state ASSERT, counter=0, k=0.
  - All ov_rst_n_stage=0 and o_seq_done=0 on the next cycle.
  - req has priority over all other transitions in the same cycle, including a ready that arrives together with it.
- o_timeout_err and ov_fail_stage:
  - Cleared only by i_rst or by i_soft_rst (clear is visible the cycle after the pulse).
  - A glitch-filter reset does not clear them.
- Timing with ready held high:
  - Stage 0 rises at cycle HOLD_CYC+1 after the first request-free cycle (cycle 0).
  - Each subsequent stage rises GAP_CYC+2 cycles after the previous one.
  - o_seq_done rises GAP_CYC+1 cycles after the last stage rises.
- Counter widths: compare against parameters minus 1; no wrap is permitted (the CNT_W sizing rule above guarantees this).

Test Plan:
1. Normal sequence. i_rst high for 3 cycles; release at cycle 0; i_rst_n_glitch=1; iv_stage_ready=4'hF.
   -> ov_rst_n_stage bits rise at cycles 17, 27, 37, 47 (1, 3, 7, F); o_seq_done=1 at cycle 56.
2. Hold restart. i_rst_n_glitch pulses low for 1 cycle at cycle 10 during ASSERT.
   -> stage 0 rises at cycle 28, not 17.
3. Late ready. iv_stage_ready[1] asserted 50 cycles after stage 1 releases.
   -> stage 2 rises exactly 2 cycles after ready is first sampled high; no error.
4. Timeout. iv_stage_ready[2] held at 0.
   -> o_timeout_err=1 and ov_fail_stage=2 exactly 8+1024 cycles after stage 2 rises; ov_rst_n_stage stays 4'h7; o_seq_done=0.
5. Error clearing. From case 4, i_rst_n_glitch low then high.
   -> full re-sequence runs, o_timeout_err stays 1. A subsequent i_soft_rst pulse clears the error, forces ov_rst_n_stage=0 the next cycle, and restarts the sequence.
6. Reset mid-operation. i_soft_rst while in DONE, and again in the same cycle that iv_stage_ready[k] first goes high during WAIT.
   -> both cases: ASSERT next cycle, all resets low, o_seq_done=0, no stage advance.
